// File: rtl/alu_sequencer.sv
// Operand/opcode sequencer feeding the combinational ALU.
// Issues one queued opcode per step strobe and writes {B,C} back into {A,B}.
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic               ld_valid_i,
    input  logic [2*WIDTH-1:0] ld_ab_i,
    output logic               ld_ready_o,
    input  logic               cmd_valid_i,
    input  logic [2:0]         cmd_ctl_i,
    output logic               cmd_ready_o,
    input  logic               go_i,
    output logic               alu_en_o,
    output logic [2:0]         alu_ctl_o,
    output logic [2*WIDTH-1:0] alu_ab_o,
    input  logic [2*WIDTH-1:0] alu_bc_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   res_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT, EXEC, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] ab;
    logic [WIDTH-1:0]   res;
    logic [2:0]         fifo [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        rd_inc;
    logic               empty;
    logic               full;
    logic               last;
    logic               push;
    logic               pop;

    // Pointers carry one wrap bit so full and empty are distinguishable
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_inc = rd_ptr + PTR_ONE;
    assign last   = (rd_inc == wr_ptr);

    assign push = cmd_valid_i && cmd_ready_o;
    assign pop  = (state == EXEC);

    assign alu_ctl_o = empty ? 3'b000 : fifo[rd_ptr[AW-1:0]];
    assign alu_ab_o  = ab;
    assign res_o     = res;

    always_comb begin
        state_nxt   = state;
        ld_ready_o  = 1'b0;
        cmd_ready_o = 1'b0;
        alu_en_o    = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (state)
            IDLE: begin
                ld_ready_o  = 1'b1;
                cmd_ready_o = !full;
                if (go_i) begin
                    // A same-cycle push counts toward the run
                    state_nxt = (empty && !(cmd_valid_i && !full))
                              ? DONE : WAIT;
                end
            end
            WAIT: begin
                busy_o = 1'b1;
                if (tick_i) state_nxt = EXEC;
            end
            EXEC: begin
                busy_o    = 1'b1;
                alu_en_o  = 1'b1;
                state_nxt = last ? DONE : WAIT;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            ab     <= '0;
            res    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                fifo[wr_ptr[AW-1:0]] <= cmd_ctl_i;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_inc;
            if (state == IDLE && ld_valid_i) ab <= ld_ab_i;
            else if (pop) ab <= alu_bc_i;
            if (state == DONE) res <= ab[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: stand-in ALU, queue-based reference model,
// per-cycle output comparison plus literal checkpoints.
module tb_alu_sequencer;

    localparam int W = 8;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick;
    logic           ld_valid;
    logic [2*W-1:0] ld_ab;
    logic           ld_ready;
    logic           cmd_valid;
    logic [2:0]     cmd_ctl;
    logic           cmd_ready;
    logic           go;
    logic           alu_en;
    logic [2:0]     alu_ctl;
    logic [2*W-1:0] alu_ab;
    logic [2*W-1:0] alu_bc;
    logic           busy;
    logic           done;
    logic [W-1:0]   res;

    int n_cmp = 0;
    int n_err = 0;
    int en_cnt = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    // Stand-in ALU: output {B, f(A,B)}
    function automatic logic [2*W-1:0] alu(input logic [2*W-1:0] v,
                                           input logic [2:0] c);
        logic [W-1:0] a, b, r;
        a = v[2*W-1:W];
        b = v[W-1:0];
        case (c)
            3'd0: r = a;
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = a + b;
            3'd5: r = a - b;
            3'd6: r = ~a;
            default: r = b;
        endcase
        return {b, r};
    endfunction

    assign alu_bc = alu(alu_ab, alu_ctl);

    alu_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick),
        .ld_valid_i(ld_valid), .ld_ab_i(ld_ab), .ld_ready_o(ld_ready),
        .cmd_valid_i(cmd_valid), .cmd_ctl_i(cmd_ctl),
        .cmd_ready_o(cmd_ready), .go_i(go),
        .alu_en_o(alu_en), .alu_ctl_o(alu_ctl), .alu_ab_o(alu_ab),
        .alu_bc_i(alu_bc), .busy_o(busy), .done_o(done), .res_o(res)
    );

    // Reference model: run = between go and completion, fire = op executing
    logic [2:0]     mq[$];
    logic [2*W-1:0] m_ab = '0;
    logic [W-1:0]   m_res = '0;
    bit             m_run = 0;
    bit             m_fire = 0;
    bit             m_done = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ab = '0; m_res = '0;
            m_run = 0; m_fire = 0; m_done = 0;
        end else if (m_done) begin
            m_res = m_ab[W-1:0];
            m_done = 0;
        end else if (m_fire) begin
            m_ab = alu(m_ab, mq[0]);
            void'(mq.pop_front());
            m_fire = 0;
            if (mq.size() == 0) begin
                m_run = 0;
                m_done = 1;
            end
        end else if (m_run) begin
            if (tick) m_fire = 1;
        end else begin
            if (cmd_valid && mq.size() < D) mq.push_back(cmd_ctl);
            if (ld_valid) m_ab = ld_ab;
            if (go) begin
                if (mq.size() > 0) m_run = 1;
                else m_done = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            logic idle;
            idle = !m_run && !m_fire && !m_done;
            chk("ld_ready", 32'(ld_ready), 32'(idle));
            chk("cmd_ready", 32'(cmd_ready), 32'(idle && mq.size() < D));
            chk("alu_en", 32'(alu_en), 32'(m_fire));
            chk("alu_ctl", 32'(alu_ctl),
                32'(mq.size() > 0 ? mq[0] : 3'b000));
            chk("alu_ab", 32'(alu_ab), 32'(m_ab));
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_done));
            chk("res", 32'(res), 32'(m_res));
            if (alu_en === 1'b1) en_cnt++;
        end
    end

    // One clock of stimulus; inputs return to idle afterwards
    task automatic cyc(input logic l, input logic [2*W-1:0] v,
                       input logic cv, input logic [2:0] c,
                       input logic g, input logic t, input logic r);
        ld_valid = l; ld_ab = v; cmd_valid = cv; cmd_ctl = c;
        go = g; tick = t; rst = r;
        @(posedge clk);
        #1;
        ld_valid = 0; ld_ab = '0; cmd_valid = 0; cmd_ctl = '0;
        go = 0; tick = 0; rst = 0;
    endtask

    task automatic idle1();
        cyc(0, '0, 0, 3'd0, 0, 0, 0);
    endtask

    task automatic tick1();
        cyc(0, '0, 0, 3'd0, 0, 1, 0);
    endtask

    task automatic run_one(input logic [2*W-1:0] v, input logic [2:0] c,
                           input logic [W-1:0] want, input string name);
        cyc(1, v, 1, c, 1, 0, 0);
        tick1();
        idle1();
        idle1();
        @(negedge clk);
        chk(name, 32'(res), 32'(want));
    endtask

    initial begin
        rst = 1; tick = 0; ld_valid = 0; ld_ab = '0;
        cmd_valid = 0; cmd_ctl = '0; go = 0;
        cyc(0, '0, 0, 3'd0, 0, 0, 1);
        checking = 1;
        cyc(0, '0, 0, 3'd0, 0, 0, 1);
        @(negedge clk);
        chk("rst_res", 32'(res), 32'h0);
        chk("rst_ab", 32'(alu_ab), 32'h0);
        chk("rst_ld_ready", 32'(ld_ready), 32'h1);

        // add: 05 + 03
        cyc(1, 16'h0503, 1, 3'd4, 1, 0, 0);
        tick1();
        @(negedge clk);
        chk("t1_en", 32'(alu_en), 32'h1);
        chk("t1_ab", 32'(alu_ab), 32'h0503);
        chk("t1_ctl", 32'(alu_ctl), 32'h4);
        idle1();
        @(negedge clk);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_ab2", 32'(alu_ab), 32'h0308);
        idle1();
        @(negedge clk);
        chk("t1_res", 32'(res), 32'h08);

        // sub then add
        cyc(1, 16'h1001, 1, 3'd5, 0, 0, 0);
        cyc(0, '0, 1, 3'd4, 1, 0, 0);
        @(negedge clk);
        chk("t2_busy", 32'(busy), 32'h1);
        tick1();
        idle1();
        @(negedge clk);
        chk("t2_ab1", 32'(alu_ab), 32'h010F);
        tick1();
        idle1();
        @(negedge clk);
        chk("t2_ab2", 32'(alu_ab), 32'h0F10);
        chk("t2_done", 32'(done), 32'h1);
        idle1();
        @(negedge clk);
        chk("t2_res", 32'(res), 32'h10);

        run_one(16'hFF02, 3'd4, 8'h01, "wrap_add");
        run_one(16'h0001, 3'd5, 8'hFF, "wrap_sub");

        // go with empty FIFO
        cyc(1, 16'h2A17, 0, 3'd0, 1, 0, 0);
        @(negedge clk);
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_en", 32'(alu_en), 32'h0);
        idle1();
        @(negedge clk);
        chk("t5_res", 32'(res), 32'h17);

        // overfill: fifth push dropped
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 1, 3'(i), 0, 0, 0);
            if (i == 3) begin
                @(negedge clk);
                chk("t4_full", 32'(cmd_ready), 32'h0);
            end
        end
        en_cnt = 0;
        cyc(0, '0, 0, 3'd0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick1();
            idle1();
        end
        @(negedge clk);
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_ab", 32'(alu_ab), 32'h2A28);
        idle1();
        @(negedge clk);
        chk("t4_en_cnt", 32'(en_cnt), 32'd4);
        chk("t4_res", 32'(res), 32'h28);

        // tick during EXEC ignored, then reset mid-run
        cyc(0, '0, 1, 3'd4, 0, 0, 0);
        cyc(0, '0, 1, 3'd5, 1, 0, 0);
        tick1();
        @(negedge clk);
        chk("t6_en", 32'(alu_en), 32'h1);
        tick1();
        @(negedge clk);
        chk("t6_no_early", 32'(alu_en), 32'h0);
        idle1();
        @(negedge clk);
        chk("t6_wait", 32'(busy), 32'h1);
        chk("t6_still", 32'(alu_en), 32'h0);
        cyc(0, '0, 0, 3'd0, 0, 0, 1);
        @(negedge clk);
        chk("t6_idle", 32'(ld_ready), 32'h1);
        chk("t6_res0", 32'(res), 32'h0);
        chk("t6_empty", 32'(alu_ctl), 32'h0);
        chk("t6_nodone", 32'(done), 32'h0);
        idle1();
        @(negedge clk);
        chk("t6_nodone2", 32'(done), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
